// File: rtl/ysyx_22050710_lsu_if.sv
// rtl/ysyx_22050710_lsu_if.sv - request, datamem and completion bundle of the load/store unit
interface ysyx_22050710_lsu_if #(parameter int XLEN = 64);
  logic            i_valid;
  logic            o_ready;
  logic [XLEN-1:0] i_addr;
  logic [XLEN-1:0] i_wdata;
  logic [2:0]      i_MemOP;
  logic            i_WrEn;
  logic [XLEN-1:0] o_mem_addr;
  logic            o_mem_ren;
  logic            o_mem_wen;
  logic [7:0]      o_mem_wmask;
  logic [XLEN-1:0] o_mem_wdata;
  logic [XLEN-1:0] i_mem_rdata;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_rdata;
  logic            o_misalign;

  modport slave (
    input  i_valid, i_addr, i_wdata, i_MemOP, i_WrEn, i_mem_rdata, i_ready,
    output o_ready, o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wmask, o_mem_wdata,
           o_valid, o_rdata, o_misalign
  );

  modport master (
    output i_valid, i_addr, i_wdata, i_MemOP, i_WrEn, i_mem_rdata, i_ready,
    input  o_ready, o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wmask, o_mem_wdata,
           o_valid, o_rdata, o_misalign
  );
endinterface

// File: rtl/ysyx_22050710_lsu.sv
// rtl/ysyx_22050710_lsu.sv - load/store unit splitting requests into aligned 8-byte datamem beats
// YSYX_22050710_LSU_MISALIGN_EN: when defined, dword-crossing accesses run as two beats instead of faulting.
module ysyx_22050710_lsu #(
  parameter int XLEN = 64
) (
  input logic                 i_clk,
  input logic                 i_rst,
  ysyx_22050710_lsu_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, wdata_q, rd0_q, rd1_q;
  logic [2:0]      op_q;
  logic            wr_q;

  function automatic logic crossing(input logic [2:0] op, input logic [2:0] off);
    logic [3:0] n;
    n = 4'd1 << op[2:1];
    return ({1'b0, off} + n) > 4'd8;
  endfunction

  logic [2:0]      off;
  logic [7:0]      lane_m;
  logic [15:0]     bm;
  logic [XLEN-1:0] base;
  logic [127:0]    cat;
  logic [XLEN-1:0] raw, ext;

  assign off  = addr_q[2:0];
  assign base = {addr_q[XLEN-1:3], 3'b000};
  assign bm   = {8'h00, lane_m} << off;
  assign cat  = {rd1_q, rd0_q} >> {off, 3'b000};
  assign raw  = cat[XLEN-1:0];

  always_comb begin
    lane_m = 8'h00;
    case (op_q[2:1])
      2'd0:    lane_m = 8'h01;
      2'd1:    lane_m = 8'h03;
      2'd2:    lane_m = 8'h0F;
      default: lane_m = 8'hFF;
    endcase
  end

  always_comb begin
    ext = '0;
    case (op_q)
      3'b000:  ext = {{56{raw[7]}}, raw[7:0]};
      3'b001:  ext = {56'd0, raw[7:0]};
      3'b010:  ext = {{48{raw[15]}}, raw[15:0]};
      3'b011:  ext = {48'd0, raw[15:0]};
      3'b100:  ext = {{32{raw[31]}}, raw[31:0]};
      3'b101:  ext = {32'd0, raw[31:0]};
      3'b110:  ext = raw;
      default: ext = '0;
    endcase
  end

`ifdef YSYX_22050710_LSU_MISALIGN_EN
  logic cross_w;
  assign cross_w = (op_q != 3'b111) && crossing(op_q, off);
  assign bus.o_misalign = 1'b0;
  assign bus.o_rdata = (state_q == RESP && !wr_q) ? ext : '0;
`else
  logic mis_q;
  assign bus.o_misalign = (state_q == RESP) && mis_q;
  assign bus.o_rdata = (state_q == RESP && !wr_q && !mis_q) ? ext : '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= 3'b111;
      wr_q    <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
`ifndef YSYX_22050710_LSU_MISALIGN_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      if (state_q == IDLE && bus.i_valid) begin
        addr_q  <= bus.i_addr;
        wdata_q <= bus.i_wdata;
        op_q    <= bus.i_MemOP;
        wr_q    <= bus.i_WrEn;
        rd0_q   <= '0;
        rd1_q   <= '0;
`ifndef YSYX_22050710_LSU_MISALIGN_EN
        mis_q   <= (bus.i_MemOP != 3'b111) && crossing(bus.i_MemOP, bus.i_addr[2:0]);
`endif
      end
      if (state_q == ACC0 && !wr_q) rd0_q <= bus.i_mem_rdata;
      if (state_q == ACC1 && !wr_q) rd1_q <= bus.i_mem_rdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    bus.o_ready     = 1'b0;
    bus.o_valid     = 1'b0;
    bus.o_mem_addr  = '0;
    bus.o_mem_ren   = 1'b0;
    bus.o_mem_wen   = 1'b0;
    bus.o_mem_wmask = 8'h00;
    bus.o_mem_wdata = '0;
    case (state_q)
      IDLE: begin
        bus.o_ready = 1'b1;
        if (bus.i_valid) begin
          if (bus.i_MemOP == 3'b111) state_d = RESP;
`ifndef YSYX_22050710_LSU_MISALIGN_EN
          else if (crossing(bus.i_MemOP, bus.i_addr[2:0])) state_d = RESP;
`endif
          else state_d = ACC0;
        end
      end
      ACC0: begin
        bus.o_mem_addr = base;
        bus.o_mem_ren  = !wr_q;
        bus.o_mem_wen  = wr_q;
        if (wr_q) begin
          bus.o_mem_wmask = bm[7:0];
          bus.o_mem_wdata = wdata_q << {off, 3'b000};
        end
`ifdef YSYX_22050710_LSU_MISALIGN_EN
        state_d = cross_w ? ACC1 : RESP;
`else
        state_d = RESP;
`endif
      end
      ACC1: begin
        bus.o_mem_addr = base + 64'd8;
        bus.o_mem_ren  = !wr_q;
        bus.o_mem_wen  = wr_q;
        if (wr_q) begin
          bus.o_mem_wmask = bm[15:8];
          bus.o_mem_wdata = wdata_q >> (7'd64 - {1'b0, off, 3'b000});
        end
        state_d = RESP;
      end
      RESP: begin
        bus.o_valid = 1'b1;
        if (bus.i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a beat caught by reset must never reach the memory
    if (i_rst) begin
      bus.o_mem_ren = 1'b0;
      bus.o_mem_wen = 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_22050710_lsu.sv
// tb/tb_ysyx_22050710_lsu.sv - directed-vector bench for the load/store unit
module tb_ysyx_22050710_lsu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_22050710_lsu_if bus ();
  ysyx_22050710_lsu dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  logic [63:0] mem [0:7];
  assign bus.i_mem_rdata = bus.o_mem_ren ? mem[bus.o_mem_addr[5:3]] : 64'h0;

  int n_vec = 0;
  int n_err = 0;
  int lat, nb, nren, nwen;
  logic [63:0] b_addr  [0:3];
  logic [7:0]  b_mask  [0:3];
  logic [63:0] b_wdata [0:3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one request, runs it up to RESP and records every strobed beat.
  task automatic issue(input string tag, input logic [2:0] op, input logic wr,
                       input logic [63:0] a, input logic [63:0] wd);
    logic [2:0] idx;
    nb = 0; nren = 0; nwen = 0;
    bus.i_valid = 1'b1; bus.i_MemOP = op; bus.i_WrEn = wr;
    bus.i_addr = a; bus.i_wdata = wd;
    chk({tag, ".ready"}, bus.o_ready, 1);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    lat = 1;
    while (!bus.o_valid && lat < 8) begin
      if (bus.o_mem_ren || bus.o_mem_wen) begin
        if (nb < 4) begin
          b_addr[nb]  = bus.o_mem_addr;
          b_mask[nb]  = bus.o_mem_wmask;
          b_wdata[nb] = bus.o_mem_wdata;
        end
        if (bus.o_mem_ren) nren++;
        if (bus.o_mem_wen) begin
          nwen++;
          idx = bus.o_mem_addr[5:3];
          for (int k = 0; k < 8; k++)
            if (bus.o_mem_wmask[k]) mem[idx][8*k +: 8] = bus.o_mem_wdata[8*k +: 8];
        end
        nb++;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".valid"}, bus.o_valid, 1);
  endtask

  task automatic finish_resp(input string tag);
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_ready = 1'b0;
    chk({tag, ".valid_drop"}, bus.o_valid, 0);
    chk({tag, ".ready_back"}, bus.o_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_valid = 1'b0; bus.i_ready = 1'b0; bus.i_addr = '0; bus.i_wdata = '0;
    bus.i_MemOP = 3'b111; bus.i_WrEn = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 64'h0;
    mem[0] = 64'hF011223344556677;
    mem[2] = 64'h8877665544332211;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", bus.o_valid, 0);
    chk("rst.ready", bus.o_ready, 1);
    chk("rst.rdata", bus.o_rdata, 0);
    chk("rst.mis", bus.o_misalign, 0);
    chk("rst.ren", bus.o_mem_ren, 0);
    chk("rst.wen", bus.o_mem_wen, 0);
    chk("rst.addr", bus.o_mem_addr, 0);
    chk("rst.wmask", bus.o_mem_wmask, 0);
    chk("rst.wdata", bus.o_mem_wdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue("ld", 3'b110, 1'b0, 64'h80000010, 64'h0);
    chk("ld.lat", lat, 2);
    chk("ld.nren", nren, 1);
    chk("ld.addr", b_addr[0], 64'h80000010);
    chk("ld.rdata", bus.o_rdata, 64'h8877665544332211);
    finish_resp("ld");

    issue("lb", 3'b000, 1'b0, 64'h80000007, 64'h0);
    chk("lb.addr", b_addr[0], 64'h80000000);
    chk("lb.rdata", bus.o_rdata, 64'hFFFFFFFFFFFFFFF0);
    finish_resp("lb");

    issue("lbu", 3'b001, 1'b0, 64'h80000007, 64'h0);
    chk("lbu.rdata", bus.o_rdata, 64'h00000000000000F0);
    finish_resp("lbu");

    issue("lh2", 3'b010, 1'b0, 64'h80000002, 64'h0);
    chk("lh2.lat", lat, 2);
    chk("lh2.nren", nren, 1);
    chk("lh2.rdata", bus.o_rdata, 64'h0000000000004455);
    finish_resp("lh2");

    issue("lw4", 3'b100, 1'b0, 64'h80000004, 64'h0);
    chk("lw4.rdata", bus.o_rdata, 64'hFFFFFFFFF0112233);
    finish_resp("lw4");

    issue("lwu4", 3'b101, 1'b0, 64'h80000004, 64'h0);
    chk("lwu4.rdata", bus.o_rdata, 64'h00000000F0112233);
    finish_resp("lwu4");

    issue("sw6", 3'b100, 1'b1, 64'h80000006, 64'h00000000AABBCCDD);
    chk("sw6.rdata", bus.o_rdata, 0);
`ifdef YSYX_22050710_LSU_MISALIGN_EN
    chk("sw6.lat", lat, 3);
    chk("sw6.nwen", nwen, 2);
    chk("sw6.addr0", b_addr[0], 64'h80000000);
    chk("sw6.mask0", b_mask[0], 8'hC0);
    chk("sw6.wdata0", b_wdata[0], 64'hCCDD000000000000);
    chk("sw6.addr1", b_addr[1], 64'h80000008);
    chk("sw6.mask1", b_mask[1], 8'h03);
    chk("sw6.wdata1", b_wdata[1], 64'h000000000000AABB);
    chk("sw6.mis", bus.o_misalign, 0);
`else
    chk("sw6.lat", lat, 1);
    chk("sw6.nbeat", nb, 0);
    chk("sw6.mis", bus.o_misalign, 1);
`endif
    finish_resp("sw6");

    mem[1] = 64'h1234AABBCCDDEEFF;
    mem[2] = 64'h5566778899AA8000;
    issue("lwx", 3'b100, 1'b0, 64'h8000000E, 64'h0);
`ifdef YSYX_22050710_LSU_MISALIGN_EN
    chk("lwx.lat", lat, 3);
    chk("lwx.nren", nren, 2);
    chk("lwx.addr0", b_addr[0], 64'h80000008);
    chk("lwx.addr1", b_addr[1], 64'h80000010);
    chk("lwx.rdata", bus.o_rdata, 64'hFFFFFFFF80001234);
    chk("lwx.mis", bus.o_misalign, 0);
`else
    chk("lwx.lat", lat, 1);
    chk("lwx.nbeat", nb, 0);
    chk("lwx.rdata", bus.o_rdata, 0);
    chk("lwx.mis", bus.o_misalign, 1);
`endif
    finish_resp("lwx");

    mem[7] = 64'h7F6E000000000000;
    mem[0] = 64'h0000000000000201;
    issue("lwwrap", 3'b100, 1'b0, 64'hFFFFFFFFFFFFFFFE, 64'h0);
`ifdef YSYX_22050710_LSU_MISALIGN_EN
    chk("lwwrap.addr0", b_addr[0], 64'hFFFFFFFFFFFFFFF8);
    chk("lwwrap.addr1", b_addr[1], 64'h0);
    chk("lwwrap.rdata", bus.o_rdata, 64'h0000000002017F6E);
`else
    chk("lwwrap.nbeat", nb, 0);
    chk("lwwrap.mis", bus.o_misalign, 1);
`endif
    finish_resp("lwwrap");

    issue("bp", 3'b110, 1'b0, 64'h80000010, 64'h0);
    for (int c = 0; c < 5; c++) begin
      chk("bp.valid", bus.o_valid, 1);
      chk("bp.rdata", bus.o_rdata, 64'h5566778899AA8000);
      chk("bp.ready", bus.o_ready, 0);
      chk("bp.strobe", {62'd0, bus.o_mem_ren, bus.o_mem_wen}, 0);
      @(posedge clk); #1;
    end
    finish_resp("bp");

    issue("nop", 3'b111, 1'b1, 64'h80000010, 64'hDEADBEEFDEADBEEF);
    chk("nop.lat", lat, 1);
    chk("nop.nbeat", nb, 0);
    chk("nop.rdata", bus.o_rdata, 0);
    chk("nop.mis", bus.o_misalign, 0);
    finish_resp("nop");

    issue("sd", 3'b110, 1'b1, 64'h80000018, 64'h0123456789ABCDEF);
    chk("sd.lat", lat, 2);
    chk("sd.mask", b_mask[0], 8'hFF);
    chk("sd.wdata", b_wdata[0], 64'h0123456789ABCDEF);
    finish_resp("sd");

    // reset lands while a store beat is on the bus
    bus.i_valid = 1'b1; bus.i_MemOP = 3'b110; bus.i_WrEn = 1'b1;
    bus.i_addr = 64'h80000000; bus.i_wdata = 64'h1111111111111111;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    chk("racc.wen_before", bus.o_mem_wen, 1);
    rst = 1'b1;
    #1;
    chk("racc.wen_forced", bus.o_mem_wen, 0);
    chk("racc.ren_forced", bus.o_mem_ren, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("racc.valid", bus.o_valid, 0);
    chk("racc.ready", bus.o_ready, 1);
    @(posedge clk); #1;
    chk("racc.idle_wen", bus.o_mem_wen, 0);
    chk("racc.idle_ready", bus.o_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
